// File: rtl/pkt_vec_builder.sv
`default_nettype none
// pkt_vec_builder: packs the first MAX_SEGS beats of each AXI-Stream packet into one wide vector.
// Optional macro PKT_VEC_LEN_CHECK_EN adds the length-mismatch flag and the len_err_cnt port.
module pkt_vec_builder #(
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int MAX_SEGS             = 4,
  localparam int VEC_WIDTH           = 144 + MAX_SEGS*C_S_AXIS_DATA_WIDTH
) (
  input  logic                              clk,
  input  logic                              aresetn,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                              s_axis_tvalid,
  output logic                              s_axis_tready,
  input  logic                              s_axis_tlast,
  output logic [VEC_WIDTH-1:0]              vec_data,
  output logic                              vec_valid,
`ifdef PKT_VEC_LEN_CHECK_EN
  output logic [15:0]                       len_err_cnt,
`endif
  input  logic                              vec_ready
);

  localparam int KEEP_W = C_S_AXIS_DATA_WIDTH/8;
  localparam int POP_W  = $clog2(KEEP_W+1);
  localparam logic [2:0] SEG_LIMIT = 3'(MAX_SEGS);

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    CAPTURE = 1'b1
  } state_t;

  state_t state, state_nxt;

  logic [MAX_SEGS-1:0][C_S_AXIS_DATA_WIDTH-1:0] segs, segs_nxt;
  logic [127:0]   meta, meta_nxt;
  logic [7:0]     tot_len, tot_len_nxt, len_base;
  logic [8:0]     len_sum;
  logic [2:0]     seg_cnt, seg_cnt_nxt;
  logic           trunc, trunc_nxt;
  logic           beat, pkt_done, len_err;
  logic [POP_W-1:0] keep_pop;
  logic [VEC_WIDTH-1:0] vec_nxt;

  // A finished vector blocks the stream only until the consumer takes it.
  assign s_axis_tready = ~vec_valid | vec_ready;
  assign beat          = s_axis_tvalid & s_axis_tready;

  always_comb begin
    keep_pop = '0;
    for (int i = 0; i < KEEP_W; i++) begin
      keep_pop = keep_pop + POP_W'(s_axis_tkeep[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!aresetn) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    segs_nxt    = segs;
    meta_nxt    = meta;
    tot_len_nxt = tot_len;
    seg_cnt_nxt = seg_cnt;
    trunc_nxt   = trunc;
    pkt_done    = 1'b0;
    len_base    = (state == IDLE) ? 8'd0 : tot_len;
    len_sum     = {1'b0, len_base} + 9'(keep_pop);
    if (beat) begin
      tot_len_nxt = len_sum[8] ? 8'hFF : len_sum[7:0];
      pkt_done    = s_axis_tlast;
      case (state)
        IDLE: begin
          segs_nxt    = '0;
          segs_nxt[0] = s_axis_tdata;
          meta_nxt    = 128'(s_axis_tuser);
          seg_cnt_nxt = 3'd1;
          trunc_nxt   = 1'b0;
          state_nxt   = CAPTURE;
        end
        CAPTURE: begin
          if (seg_cnt < SEG_LIMIT) begin
            for (int k = 0; k < MAX_SEGS; k++) begin
              if (3'(k) == seg_cnt) segs_nxt[k] = s_axis_tdata;
            end
            seg_cnt_nxt = seg_cnt + 3'd1;
          end else begin
            trunc_nxt = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
      if (s_axis_tlast) state_nxt = IDLE;
    end
  end

`ifdef PKT_VEC_LEN_CHECK_EN
  logic [7:0] len_limit;
  always_comb begin
    len_limit = (meta_nxt[15:0] > 16'd255) ? 8'hFF : meta_nxt[7:0];
    len_err   = (tot_len_nxt != len_limit);
  end

  always_ff @(posedge clk) begin
    if (!aresetn)                 len_err_cnt <= 16'd0;
    else if (pkt_done && len_err) len_err_cnt <= len_err_cnt + 16'd1;
  end
`else
  assign len_err = 1'b0;
`endif

  assign vec_nxt = {segs_nxt, 3'b000, len_err, trunc_nxt, seg_cnt_nxt, tot_len_nxt, meta_nxt};

  // The finishing beat is folded in directly, so the vector appears one cycle after tlast.
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      segs      <= '0;
      meta      <= '0;
      tot_len   <= '0;
      seg_cnt   <= '0;
      trunc     <= 1'b0;
      vec_data  <= '0;
      vec_valid <= 1'b0;
    end else if (pkt_done) begin
      segs      <= '0;
      meta      <= '0;
      tot_len   <= '0;
      seg_cnt   <= '0;
      trunc     <= 1'b0;
      vec_data  <= vec_nxt;
      vec_valid <= 1'b1;
    end else begin
      segs    <= segs_nxt;
      meta    <= meta_nxt;
      tot_len <= tot_len_nxt;
      seg_cnt <= seg_cnt_nxt;
      trunc   <= trunc_nxt;
      if (vec_ready) vec_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pkt_vec_builder.sv
`default_nettype none
// tb_pkt_vec_builder: randomized stream traffic checked against a packet-level reference model.
module tb_pkt_vec_builder;

  localparam int DW = 256;
  localparam int UW = 128;
  localparam int MS = 4;
  localparam int KW = DW/8;
  localparam int VW = 144 + MS*DW;

  logic          clk = 1'b0;
  logic          aresetn = 1'b0;
  logic [DW-1:0] s_axis_tdata = '0;
  logic [KW-1:0] s_axis_tkeep = '0;
  logic [UW-1:0] s_axis_tuser = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic          s_axis_tlast = 1'b0;
  logic [VW-1:0] vec_data;
  logic          vec_valid;
  logic          vec_ready = 1'b0;
`ifdef PKT_VEC_LEN_CHECK_EN
  logic [15:0]   len_err_cnt;
`endif

  always #5 clk = ~clk;

  pkt_vec_builder #(
    .C_S_AXIS_DATA_WIDTH (DW),
    .C_S_AXIS_TUSER_WIDTH(UW),
    .MAX_SEGS            (MS)
  ) dut (
    .clk          (clk),
    .aresetn      (aresetn),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tkeep (s_axis_tkeep),
    .s_axis_tuser (s_axis_tuser),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .s_axis_tlast (s_axis_tlast),
    .vec_data     (vec_data),
    .vec_valid    (vec_valid),
`ifdef PKT_VEC_LEN_CHECK_EN
    .len_err_cnt  (len_err_cnt),
`endif
    .vec_ready    (vec_ready)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: expected vector held until its handshake.
  bit            exp_valid = 1'b0;
  logic [UW-1:0] exp_meta = '0;
  int            exp_len = 0, exp_cnt = 0;
  bit            exp_trunc = 1'b0, exp_lerr = 1'b0;
  logic [DW-1:0] exp_seg[MS];
  logic [15:0]   exp_lec = '0;
  logic [DW-1:0] cap_d[$];
  logic [KW-1:0] cap_k[$];
  logic [UW-1:0] cap_u;

  // Driver state
  logic [DW-1:0] drv_d[$];
  logic [KW-1:0] drv_k[$];
  logic [UW-1:0] drv_u;
  int            drv_pos = 0;
  int            pkt_num = 0;
  int            ready_hold = 0;
  bit            fast = 1'b0;
  bit            took = 1'b0;

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] w;
    for (int i = 0; i < DW/32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  task automatic check_vec(input string tag);
    logic [2:0] zero3;
    zero3 = '0;
    check({tag, ".tuser"}, vec_data[127:0], exp_meta);
    check({tag, ".tot_length"}, vec_data[135:128], exp_len[7:0]);
    check({tag, ".seg_count"}, vec_data[138:136], exp_cnt[2:0]);
    check({tag, ".trunc"}, vec_data[139], exp_trunc);
    check({tag, ".len_err"}, vec_data[140], exp_lerr);
    check({tag, ".pad"}, vec_data[143:141], zero3);
    for (int k = 0; k < MS; k++)
      check($sformatf("%s.seg%0d", tag, k), vec_data[144+k*DW +: DW], exp_seg[k]);
  endtask

  task automatic build_expected();
    int n, tot, lim;
    n = cap_d.size();
    tot = 0;
    for (int k = 0; k < MS; k++) exp_seg[k] = '0;
    for (int i = 0; i < n; i++) begin
      if (i < MS) exp_seg[i] = cap_d[i];
      tot += $countones(cap_k[i]);
    end
    exp_meta  = cap_u;
    exp_len   = (tot > 255) ? 255 : tot;
    exp_cnt   = (n < MS) ? n : MS;
    exp_trunc = (n > MS);
    lim = (cap_u[15:0] > 16'd255) ? 255 : int'(cap_u[15:0]);
`ifdef PKT_VEC_LEN_CHECK_EN
    exp_lerr = (exp_len != lim);
    if (exp_lerr) exp_lec = exp_lec + 16'd1;
`else
    exp_lerr = 1'b0;
`endif
    exp_valid = 1'b1;
    cap_d.delete();
    cap_k.delete();
  endtask

  task automatic new_packet();
    int n, mode, lenfld, bytes;
    drv_d.delete();
    drv_k.delete();
    drv_pos = 0;
    fast = (pkt_num >= 5 && pkt_num < 14);
    case (pkt_num)
      0:       n = 1;
      1:       n = 3;
      2:       n = 6;
      3, 4:    n = 2;
      14:      n = 2;
      default: n = fast ? 1 : int'($urandom_range(1, 8));
    endcase
    bytes = 0;
    for (int i = 0; i < n; i++) begin
      logic [KW-1:0] kp;
      drv_d.push_back(rand_word());
      if (pkt_num == 0)                     kp = 32'h0000_FFFF;
      else if (pkt_num == 1 && i == 2)      kp = 32'h0000_000F;
      else if (pkt_num < 5)                 kp = '1;
      else begin
        mode = $urandom_range(0, 3);
        case (mode)
          0:       kp = '1;
          1:       kp = '0;
          2:       kp = $urandom;
          default: kp = 32'hFFFF_FFFF >> $urandom_range(0, 31);
        endcase
      end
      drv_k.push_back(kp);
      bytes += $countones(kp);
    end
    case (pkt_num)
      0:       lenfld = 16;
      3:       lenfld = 60;
      4:       lenfld = 64;
      default: lenfld = ($urandom_range(0, 1) == 1) ? bytes : int'($urandom_range(0, 400));
    endcase
    drv_u = {rand_word()[UW-1:16], 16'(lenfld)};
    if (pkt_num == 3) ready_hold = 5;
    else if (pkt_num >= 15 && $urandom_range(0, 9) == 0) ready_hold = $urandom_range(1, 6);
    pkt_num++;
  endtask

  task automatic step();
    bit hs, acc, last;
    @(negedge clk);
    if (drv_d.size() == 0) new_packet();
    if (!s_axis_tvalid || took) s_axis_tvalid = fast || ($urandom_range(0, 3) != 0);
    took = 1'b0;
    s_axis_tdata = drv_d[drv_pos];
    s_axis_tkeep = drv_k[drv_pos];
    s_axis_tuser = (drv_pos == 0) ? drv_u : ~drv_u;
    s_axis_tlast = (drv_pos == drv_d.size() - 1);
    if (ready_hold > 0) begin
      vec_ready = 1'b0;
      ready_hold--;
    end else begin
      vec_ready = fast || ($urandom_range(0, 3) != 0);
    end
    #1;
    check("vec_valid", vec_valid, exp_valid);
    if (exp_valid) check_vec("vec");
    check("s_axis_tready", s_axis_tready, !exp_valid || vec_ready);
`ifdef PKT_VEC_LEN_CHECK_EN
    check("len_err_cnt", len_err_cnt, exp_lec);
`endif
    hs  = exp_valid && vec_ready;
    acc = s_axis_tvalid && (!exp_valid || vec_ready);
    if (hs) exp_valid = 1'b0;
    if (acc) begin
      if (cap_d.size() == 0) cap_u = s_axis_tuser;
      cap_d.push_back(s_axis_tdata);
      cap_k.push_back(s_axis_tkeep);
      last = s_axis_tlast;
      drv_pos++;
      took = 1'b1;
      if (last) begin
        build_expected();
        drv_d.delete();
        drv_k.delete();
      end
    end
    @(posedge clk);
  endtask

  task automatic do_reset();
    logic [2:0] zero3;
    zero3 = '0;
    @(negedge clk);
    aresetn = 1'b0;
    s_axis_tvalid = 1'b0;
    vec_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1;
    check("rst.tready", s_axis_tready, 1'b1);
    check("rst.vec_valid", vec_valid, 1'b0);
    check("rst.vec_meta", vec_data[143:0], {zero3, 141'd0});
    for (int k = 0; k < MS; k++)
      check($sformatf("rst.seg%0d", k), vec_data[144+k*DW +: DW], '0);
`ifdef PKT_VEC_LEN_CHECK_EN
    check("rst.len_err_cnt", len_err_cnt, 16'd0);
`endif
    aresetn = 1'b1;
    exp_valid = 1'b0;
    exp_lec = '0;
    cap_d.delete();
    cap_k.delete();
    drv_d.delete();
    drv_k.delete();
    drv_pos = 0;
    took = 1'b0;
    ready_hold = 0;
  endtask

  initial begin
    int guard;
    do_reset();
    guard = 0;
    while (pkt_num < 14 && guard < 2000) begin step(); guard++; end
    guard = 0;
    while (drv_d.size() != 0 && guard < 200) begin step(); guard++; end
    check("directed_budget", (drv_d.size() == 0), 1'b1);

    // Abort a 4-beat packet after two accepted beats.
    pkt_num = 100;
    drv_pos = 0;
    fast = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drv_d.push_back(rand_word());
      drv_k.push_back('1);
    end
    drv_u = rand_word()[UW-1:0];
    guard = 0;
    while (cap_d.size() < 2 && guard < 200) begin step(); guard++; end
    check("abort_budget", (cap_d.size() == 2), 1'b1);
    do_reset();
    pkt_num = 14;

    repeat (3000) step();
    ready_hold = 0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
